// File: rtl/data_scan_out.sv
// Snapshots a flat slot bus and streams it out one slot per valid/ready beat.
// Optional checksum trailer beat: define DATA_SCAN_OUT_CHECKSUM_EN.
module data_scan_out #(
    parameter int NUM_CH = 64,
    parameter int DATA_W = 11,
    parameter int IDX_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] slots_in,
    input  logic                     start,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_first,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

`ifdef DATA_SCAN_OUT_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, DONE, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic              cap, xfer, at_end;

    assign xfer   = out_valid && out_ready;
    assign at_end = (idx_q == IDX_W'(NUM_CH - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cap     = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (at_end) begin
                        idx_d = '0;
`ifdef DATA_SCAN_OUT_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef DATA_SCAN_OUT_CHECKSUM_EN
            CSUM: begin
                if (xfer) state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) shadow_q[k] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (cap) begin
                for (int k = 0; k < NUM_CH; k++)
                    shadow_q[k] <= slots_in[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef DATA_SCAN_OUT_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    // Running sum of beats already sent; complete once SEND exits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (cap) begin
            sum_q <= '0;
        end else if (state_q == SEND && xfer) begin
            sum_q <= sum_q + shadow_q[idx_q];
        end
    end

    assign out_valid = (state_q == SEND) || (state_q == CSUM);
    assign out_data  = (state_q == CSUM) ? sum_q : shadow_q[idx_q];
    assign out_last  = (state_q == CSUM);
`else
    assign out_valid = (state_q == SEND);
    assign out_data  = shadow_q[idx_q];
    assign out_last  = (state_q == SEND) && at_end;
`endif

    assign out_idx   = idx_q;
    assign out_first = (state_q == SEND) && (idx_q == '0);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule
